// File: rtl/vectorreduce_engine.sv
// Reduces a vector from one of NUM_BANKS banks (round-robin per command) by USUM/SSUM/SMAX/SMIN across SIMD lanes.
// Latency: 1 decode + size stream + 1 drain + SIMD_WIDTH combine cycles, then the result is offered.
// Backpressure: waits in RESULT/STATS while res_full; waits in IDLE/FETCH while cmd_empty.
module vectorreduce_engine #(
   parameter int SIMD_WIDTH = 4,
   parameter int W_D        = 32,
   parameter int W_A        = 10,
   parameter int NUM_BANKS  = 2,
   parameter int W_CMD      = 32,
   parameter int W_ACC      = 64,
   localparam int W_BS      = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
   input  logic                                CLK,
   input  logic                                RST,
   input  logic [W_CMD-1:0]                    cmd_q,
   input  logic                                cmd_empty,
   output logic                                cmd_deq,
   output logic [W_ACC-1:0]                    res_d,
   output logic                                res_enq,
   input  logic                                res_full,
   output logic [W_A-1:0]                      mem_addr,
   input  logic [NUM_BANKS*SIMD_WIDTH*W_D-1:0] mem_q,
   output logic [W_BS-1:0]                     bank_sel,
   output logic                                busy
);

   localparam int W_L  = (SIMD_WIDTH > 1) ? $clog2(SIMD_WIDTH) : 1;
   localparam int W_BW = SIMD_WIDTH * W_D;

   typedef enum logic [2:0] {
      S_IDLE, S_DECODE, S_STREAM, S_DRAIN, S_COMBINE, S_RESULT, S_FETCH, S_STATS
   } state_t;

   typedef enum logic [1:0] {
      OP_USUM = 2'd0, OP_SSUM = 2'd1, OP_SMAX = 2'd2, OP_SMIN = 2'd3
   } op_t;

   state_t              state, state_nxt;
   op_t                 op;
   op_t                 dec_op;
   logic [W_A:0]        size;
   logic [W_A:0]        dec_raw;
   logic [W_A:0]        dec_size;
   logic                last_addr;
   logic                rd_vld;
   logic                deq_req;
   logic                enq_req;
   logic [W_ACC-1:0]    acc [SIMD_WIDTH];
   logic [W_ACC-1:0]    lane_ext [SIMD_WIDTH];
   logic [W_BW-1:0]     bank_word;
   logic [W_ACC-1:0]    result;
   logic [W_L-1:0]      lane_idx;
   logic [W_ACC-1:0]    cyclecount;

   // Identity element of each operation: sums start at zero, max/min start at the
   // extreme W_D value so the first real lane always wins the compare.
   function automatic logic [W_ACC-1:0] init_val(input op_t o);
      logic [W_ACC-1:0] v;
      case (o)
         OP_SMAX: v = {{(W_ACC-W_D+1){1'b1}}, {(W_D-1){1'b0}}};
         OP_SMIN: v = {{(W_ACC-W_D+1){1'b0}}, {(W_D-1){1'b1}}};
         default: v = '0;
      endcase
      return v;
   endfunction

   // One reduction step, shared by lane accumulation and the final lane fold.
   function automatic logic [W_ACC-1:0] apply_op(input op_t o, input logic [W_ACC-1:0] a,
                                                 input logic [W_ACC-1:0] b);
      logic [W_ACC-1:0] v;
      case (o)
         OP_SMAX: v = ($signed(a) > $signed(b)) ? a : b;
         OP_SMIN: v = ($signed(a) < $signed(b)) ? a : b;
         default: v = a + b;
      endcase
      return v;
   endfunction

   // Command fields; sizes beyond the address space clamp to a full sweep.
   assign dec_op   = op_t'(cmd_q[W_CMD-1 -: 2]);
   assign dec_raw  = cmd_q[W_A:0];
   assign dec_size = (dec_raw[W_A] && (dec_raw[W_A-1:0] != '0)) ? {1'b1, {W_A{1'b0}}} : dec_raw;

   generate
      if (W_CMD > W_A + 3) begin : g_unused
         logic unused_cmd_bits;
         assign unused_cmd_bits = ^cmd_q[W_CMD-3:W_A+1];
      end
   endgenerate

   // The address just presented is the final one of this vector.
   assign last_addr = (({1'b0, mem_addr} + (W_A+1)'(1)) == size);

   // Pick the active bank's word and widen every lane according to the op.
   always_comb begin
      bank_word = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         if (bank_sel == W_BS'(b)) bank_word = mem_q[b*W_BW +: W_BW];
      end
      for (int i = 0; i < SIMD_WIDTH; i++) begin
         lane_ext[i] = '0;
         if (op == OP_USUM)
            lane_ext[i] = {{(W_ACC-W_D){1'b0}}, bank_word[i*W_D +: W_D]};
         else
            lane_ext[i] = {{(W_ACC-W_D){bank_word[i*W_D+W_D-1]}}, bank_word[i*W_D +: W_D]};
      end
   end

   // Next-state and handshake decisions.
   always_comb begin
      state_nxt = state;
      deq_req   = 1'b0;
      enq_req   = 1'b0;
      case (state)
         S_IDLE, S_FETCH: begin
            if (!cmd_empty) begin
               deq_req   = 1'b1;
               state_nxt = S_DECODE;
            end
         end
         S_DECODE:  state_nxt = (dec_size == '0) ? S_STATS : S_STREAM;
         S_STREAM:  if (last_addr) state_nxt = S_DRAIN;
         S_DRAIN:   state_nxt = S_COMBINE;
         S_COMBINE: if (lane_idx == W_L'(SIMD_WIDTH-1)) state_nxt = S_RESULT;
         S_RESULT, S_STATS: begin
            if (!res_full) begin
               enq_req   = 1'b1;
               state_nxt = (state == S_RESULT) ? S_FETCH : S_IDLE;
            end
         end
         default:   state_nxt = S_IDLE;
      endcase
   end

   // Handshakes are combinational so the FIFO word arrives in DECODE; reset forces them low at once.
   assign cmd_deq = RST & deq_req;
   assign res_enq = RST & enq_req;
   assign busy    = (state != S_IDLE);

   // Result port shows the reduction in RESULT and the cycle count in STATS.
   always_comb begin
      res_d = '0;
      case (state)
         S_RESULT: res_d = result;
         S_STATS:  res_d = cyclecount;
         default:  res_d = '0;
      endcase
   end

   // State register.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) state <= S_IDLE;
      else      state <= state_nxt;
   end

   // Latch the decoded command and walk the read address one word per cycle.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         op       <= OP_USUM;
         size     <= '0;
         mem_addr <= '0;
         rd_vld   <= 1'b0;
      end else begin
         rd_vld <= (state == S_STREAM);
         if (state == S_DECODE) begin
            op   <= dec_op;
            size <= dec_size;
            if (dec_size != '0) mem_addr <= '0;
         end else if (state == S_STREAM && !last_addr) begin
            mem_addr <= mem_addr + W_A'(1);
         end
      end
   end

   // Per-lane accumulation of the word read one cycle earlier.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         for (int i = 0; i < SIMD_WIDTH; i++) acc[i] <= '0;
      end else if (state == S_DECODE) begin
         for (int i = 0; i < SIMD_WIDTH; i++) acc[i] <= init_val(dec_op);
      end else if (rd_vld) begin
         for (int i = 0; i < SIMD_WIDTH; i++) acc[i] <= apply_op(op, acc[i], lane_ext[i]);
      end
   end

   // Fold the lane accumulators into one result, one lane per cycle.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         result   <= '0;
         lane_idx <= '0;
      end else if (state == S_DECODE) begin
         result   <= init_val(dec_op);
         lane_idx <= '0;
      end else if (state == S_COMBINE) begin
         result   <= apply_op(op, result, acc[lane_idx]);
         lane_idx <= lane_idx + W_L'(1);
      end
   end

   // Bank rotation: restart at bank 0 for each new command stream, step after each result.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         bank_sel <= '0;
      end else if (state == S_IDLE && deq_req) begin
         bank_sel <= '0;
      end else if (state == S_RESULT && enq_req) begin
         bank_sel <= (bank_sel == W_BS'(NUM_BANKS-1)) ? '0 : bank_sel + W_BS'(1);
      end
   end

   // Saturating busy-cycle counter; reads 0 in the first DECODE cycle.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST)                     cyclecount <= '0;
      else if (state == S_IDLE)     cyclecount <= '0;
      else if (cyclecount != '1)    cyclecount <= cyclecount + W_ACC'(1);
   end

endmodule

// File: doc/vectorreduce_engine.md
Name: vectorreduce_engine

Overview:
- Parametrised successor to the two-bank vector-sum kernel.
- Reduces a vector held in one of NUM_BANKS read-only buffer banks, selected round-robin per command, using a per-command operation (unsigned sum, signed sum, signed max, signed min) across SIMD_WIDTH lanes.
- Commands arrive on a FIFO-style command port. Results and a final cycle count leave on a FIFO-style result port.
- Sits between the control-thread channel and the bank memories in the accelerator datapath.

Parameters:
- SIMD_WIDTH, 4, lanes per memory word; 1..64.
- W_D, 32, bits per lane element.
- W_A, 10, memory address width; max vector length is 2^W_A words.
- NUM_BANKS, 2, number of buffer banks; 1..8.
- W_CMD, 32, command word width; must be at least W_A+3.
- W_ACC, 64, accumulator and result width; must be at least W_D+1.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset. Asynchronous, active-low: the block is in reset while RST=0.
- cmd_q  in  W_CMD  command word. Valid the cycle after a cmd_deq pulse; held until the next dequeue.
- cmd_empty  in  1  command FIFO empty.
- cmd_deq  out  1  dequeue pulse.
- res_d  out  W_ACC  result word.
- res_enq  out  1  enqueue pulse.
- res_full  in  1  result FIFO full.
- mem_addr  out  W_A  shared read address to all banks.
- mem_q  in  NUM_BANKS*SIMD_WIDTH*W_D  bank read data. Bank b, lane i is at bits [W_D*(b*SIMD_WIDTH+i) +: W_D]. Read latency is 1 cycle.
- bank_sel  out  clog2(NUM_BANKS) (min 1)  bank currently being reduced.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: cmd_deq=0, res_enq=0, res_d=0, mem_addr=0, bank_sel=0, busy=0. Accumulators, cycle count and state are cleared; the FSM goes to IDLE.
- Reset mid-operation aborts immediately. No partial result is emitted.
- Command decode:
  - op = cmd_q[W_CMD-1:W_CMD-2]: 0 = USUM (zero-extend), 1 = SSUM (sign-extend), 2 = SMAX, 3 = SMIN.
  - size = cmd_q[W_A:0].
  - size=0 means terminate.
  - size > 2^W_A saturates to 2^W_A.
- FSM states:
  - IDLE: cyclecount=0. If !cmd_empty, pulse cmd_deq, set bank_sel=0, go to DECODE.
  - DECODE: latch op and size. If size=0, go to STATS. Otherwise mem_addr=0, initialise all lane accumulators (0 for sums; most-negative W_D value sign-extended for SMAX; most-positive for SMIN), go to STREAM.
  - STREAM: one address per cycle. mem_addr runs 0..size-1. After issuing size-1, go to DRAIN.
  - DRAIN: one cycle to absorb the last read.
  - Data handling: data read at address a is accumulated in the cycle after a is presented. Exactly size words are accumulated, including size=1.
  - Lane accumulate: sums add W_D-extended lanes to W_ACC accumulators, wrapping modulo 2^W_ACC. Max/min use a signed compare.
  - COMBINE: sequentially fold lane 0..SIMD_WIDTH-1 into the result with the same op, one lane per cycle (SIMD_WIDTH cycles). Then go to RESULT.
  - RESULT: wait while res_full. Otherwise pulse res_enq with res_d=result, advance bank_sel=(bank_sel+1) mod NUM_BANKS, go to FETCH.
  - FETCH: if !cmd_empty, pulse cmd_deq and go to DECODE. Otherwise wait.
  - STATS: wait while res_full. Otherwise pulse res_enq with res_d=cyclecount and go to IDLE.
- cyclecount (W_ACC bits): increments every cycle outside IDLE, saturating at all-ones. It counts from the first DECODE cycle. The value emitted is the count at the enqueue cycle.
- cmd_deq and res_enq are never asserted in the same cycle, and never for more than one cycle per transaction.
- Never enqueue when res_full=1. Never dequeue when cmd_empty=1.

Test Plan:
- SIMD_WIDTH=2, bank0 words {1,2},{3,4},{5,6},{7,8}. Commands USUM size 4, then 0. Required: result 36, then a cycle count equal to measured cycles. busy falls after the count is enqueued.
- NUM_BANKS=3. Banks 0/1/2 hold all-1, all-2, all-3 lanes (SIMD_WIDTH=4). Four commands USUM size 2, then 0. Required results: 8, 16, 24, 8 (bank wrap), then the count.
- SSUM size 1 on lanes {-1,-1,-1,-1}. Required: res_d = -4 sign-extended to W_ACC, and exactly one memory word consumed.
- SMAX and SMIN size 3 over lanes {-5,-9,-2}, {-7,-3,-8}, … Required: max = largest value, min = smallest value, all negative with no zero leakage from initialisation.
- Hold res_full=1 for 10 cycles during RESULT. Required: no res_enq while full; res_d stable; the single enqueue occurs on the first cycle res_full=0.
- Drive RST=0 asynchronously in the middle of STREAM. Required: all outputs reach reset values without waiting for a clock edge. After release, a new USUM size 2 command returns the correct sum from bank 0.
